// File: rtl/paint_pkg.sv
// Shared shape codes, canvas defaults and colour constants for the painter
// and the mode selector, plus the segment table used to decompose shapes.
package paint_pkg;

  localparam int CANVAS_W_DEF = 720;
  localparam int CANVAS_H_DEF = 600;

  localparam logic [2:0] SHAPE_DIRECT = 3'd1;
  localparam logic [2:0] SHAPE_LINE   = 3'd2;
  localparam logic [2:0] SHAPE_RECT   = 3'd3;
  localparam logic [2:0] SHAPE_TRI    = 3'd4;

  localparam logic [15:0] COLOR_TRANSPARENT = 16'h0000;
  localparam logic [15:0] COLOR_BLACK       = 16'h8000;

  typedef struct packed {
    logic [12:0] xa;
    logic [12:0] ya;
    logic [12:0] xb;
    logic [12:0] yb;
  } seg_t;

  function automatic logic [2:0] num_segs(input logic [2:0] shape);
    case (shape)
      SHAPE_RECT: num_segs = 3'd4;
      SHAPE_TRI:  num_segs = 3'd3;
      default:    num_segs = 3'd1;
    endcase
  endfunction

  // Endpoints of segment 'seg' of a shape spanned by anchor (x0,y0) and corner (x1,y1).
  function automatic seg_t seg_ends(input logic [2:0] shape, input logic [1:0] seg,
                                    input logic [12:0] x0, input logic [12:0] y0,
                                    input logic [12:0] x1, input logic [12:0] y1);
    logic [12:0] xm;
    seg_t s;
    xm = 13'(({1'b0, x0} + {1'b0, x1}) >> 1);
    s.xa = x0; s.ya = y0; s.xb = x1; s.yb = y1;
    if (shape == SHAPE_RECT) begin
      case (seg)
        2'd0:    begin s.xa = x0; s.ya = y0; s.xb = x1; s.yb = y0; end
        2'd1:    begin s.xa = x1; s.ya = y0; s.xb = x1; s.yb = y1; end
        2'd2:    begin s.xa = x1; s.ya = y1; s.xb = x0; s.yb = y1; end
        default: begin s.xa = x0; s.ya = y1; s.xb = x0; s.yb = y0; end
      endcase
    end else if (shape == SHAPE_TRI) begin
      case (seg)
        2'd0:    begin s.xa = x0; s.ya = y1; s.xb = x1; s.yb = y1; end
        2'd1:    begin s.xa = x1; s.ya = y1; s.xb = xm; s.yb = y0; end
        default: begin s.xa = xm; s.ya = y0; s.xb = x0; s.yb = y1; end
      endcase
    end
    seg_ends = s;
  endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham line walker: 'start' loads a segment, each 'advance' moves to the
// next pixel; 'done' marks the current pixel as the segment endpoint.
module line_stepper (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [12:0] x0,
  input  logic [12:0] y0,
  input  logic [12:0] x1,
  input  logic [12:0] y1,
  input  logic        advance,
  output logic [12:0] px,
  output logic [12:0] py,
  output logic        valid,
  output logic        done
);

  logic               active_q, active_d;
  logic [12:0]        x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
  logic               sx_q, sx_d, sy_q, sy_d;
  logic signed [13:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic signed [13:0] ddx, ddy, adx, ady;
  logic signed [14:0] e2, dx_e, dy_e;
  logic               at_end, step_x, step_y;

  assign ddx    = $signed({1'b0, x1}) - $signed({1'b0, x0});
  assign ddy    = $signed({1'b0, y1}) - $signed({1'b0, y0});
  assign adx    = ddx[13] ? -ddx : ddx;
  assign ady    = ddy[13] ? -ddy : ddy;
  assign at_end = (x_q == xe_q) && (y_q == ye_q);
  assign e2     = $signed({err_q, 1'b0});
  assign dx_e   = $signed({dx_q[13], dx_q});
  assign dy_e   = $signed({dy_q[13], dy_q});
  assign step_x = (e2 >= dy_e);
  assign step_y = (e2 <= dx_e);

  always_comb begin
    active_d = active_q;
    x_d = x_q; y_d = y_q; xe_d = xe_q; ye_d = ye_q;
    sx_d = sx_q; sy_d = sy_q; dx_d = dx_q; dy_d = dy_q; err_d = err_q;
    if (start) begin
      // dy is kept negative so one error term serves both axes
      active_d = 1'b1;
      x_d = x0; y_d = y0; xe_d = x1; ye_d = y1;
      sx_d = ddx[13]; sy_d = ddy[13];
      dx_d = adx; dy_d = -ady; err_d = adx - ady;
    end else if (active_q && advance) begin
      if (at_end) begin
        active_d = 1'b0;
      end else begin
        err_d = err_q + (step_x ? dy_q : 14'sd0) + (step_y ? dx_q : 14'sd0);
        if (step_x) x_d = sx_q ? x_q - 13'd1 : x_q + 13'd1;
        if (step_y) y_d = sy_q ? y_q - 13'd1 : y_q + 13'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      x_q <= '0; y_q <= '0; xe_q <= '0; ye_q <= '0;
      sx_q <= 1'b0; sy_q <= 1'b0;
      dx_q <= '0; dy_q <= '0; err_q <= '0;
    end else begin
      active_q <= active_d;
      x_q <= x_d; y_q <= y_d; xe_q <= xe_d; ye_q <= ye_d;
      sx_q <= sx_d; sy_q <= sy_d;
      dx_q <= dx_d; dy_q <= dy_d; err_q <= err_d;
    end
  end

  assign px    = x_q;
  assign py    = y_q;
  assign valid = active_q;
  assign done  = active_q && at_end;

endmodule

// File: rtl/shape_painter.sv
// Turns cursor points into pixel writes for direct dots, lines, rectangles and
// triangles, and sweeps the canvas to transparent on a rising i_clear.
module shape_painter
  import paint_pkg::*;
#(
  parameter int CANVAS_W = CANVAS_W_DEF,
  parameter int CANVAS_H = CANVAS_H_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pt_valid,
  input  logic [12:0] i_pt_x,
  input  logic [12:0] i_pt_y,
  input  logic [2:0]  i_draw_shape,
  input  logic [15:0] i_color,
  input  logic        i_clear,
  output logic        o_wr_req,
  output logic [12:0] o_wr_x,
  output logic [12:0] o_wr_y,
  output logic [15:0] o_wr_data,
  input  logic        i_wr_ack,
  output logic        o_busy,
  output logic        o_drop,
  output logic [1:0]  o_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  // Write handshake: a pixel moves on a rising edge where o_wr_req and i_wr_ack
  // are both high; while o_wr_req is high without ack the address/data hold.
  logic [1:0]  state_q, state_d;
  logic [2:0]  shape_q, shape_d;
  logic [1:0]  seg_q, seg_d;
  logic [12:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [15:0] color_q, color_d;
  logic [12:0] clr_x_q, clr_x_d, clr_y_q, clr_y_d;
  logic        clr_prev_q, pend_clr_q, pend_clr_d, drop_q, drop_d;

  logic        pt_ok, clear_rise, xfer, busy;
  logic        st_start, st_valid, st_done;
  logic [12:0] st_x, st_y;
  logic [2:0]  seg_nxt;
  seg_t        st_seg;

  assign pt_ok      = i_pt_valid && (i_pt_x < 13'(CANVAS_W)) && (i_pt_y < 13'(CANVAS_H));
  assign clear_rise = i_clear && !clr_prev_q;
  assign busy       = (state_q == ST_DRAW) || (state_q == ST_CLEAR);
  assign xfer       = o_wr_req && i_wr_ack;
  assign seg_nxt    = {1'b0, seg_q} + 3'd1;

  always_comb begin
    state_d = state_q; shape_d = shape_q; seg_d = seg_q;
    x0_d = x0_q; y0_d = y0_q; x1_d = x1_q; y1_d = y1_q; color_d = color_q;
    clr_x_d = clr_x_q; clr_y_d = clr_y_q; pend_clr_d = pend_clr_q;
    drop_d = pt_ok && busy && !clear_rise;
    st_start = 1'b0;
    st_seg = seg_ends(SHAPE_LINE, 2'd0, x0_q, y0_q, x1_q, y1_q);
    case (state_q)
      ST_IDLE: begin
        if (clear_rise) begin
          state_d = ST_CLEAR; clr_x_d = '0; clr_y_d = '0;
        end else if (pt_ok && i_draw_shape == SHAPE_DIRECT) begin
          state_d = ST_DRAW; shape_d = SHAPE_DIRECT; seg_d = '0; color_d = i_color;
          st_start = 1'b1;
          st_seg = seg_ends(SHAPE_DIRECT, 2'd0, i_pt_x, i_pt_y, i_pt_x, i_pt_y);
        end else if (pt_ok && (i_draw_shape == SHAPE_LINE || i_draw_shape == SHAPE_RECT ||
                               i_draw_shape == SHAPE_TRI)) begin
          state_d = ST_ARMED; shape_d = i_draw_shape;
          x0_d = i_pt_x; y0_d = i_pt_y; color_d = i_color;
        end
      end
      ST_ARMED: begin
        if (clear_rise) begin
          state_d = ST_CLEAR; clr_x_d = '0; clr_y_d = '0;
        end else if (i_draw_shape != shape_q) begin
          state_d = ST_IDLE;
        end else if (pt_ok) begin
          state_d = ST_DRAW; seg_d = '0; x1_d = i_pt_x; y1_d = i_pt_y;
          st_start = 1'b1;
          st_seg = seg_ends(shape_q, 2'd0, x0_q, y0_q, i_pt_x, i_pt_y);
        end
      end
      ST_DRAW: begin
        if (clear_rise) pend_clr_d = 1'b1;
        if (xfer) begin
          if (pend_clr_q || clear_rise) begin
            state_d = ST_CLEAR; pend_clr_d = 1'b0; clr_x_d = '0; clr_y_d = '0;
          end else if (st_done) begin
            if (seg_nxt == num_segs(shape_q)) begin
              state_d = ST_IDLE;
            end else begin
              // next segment starts on the same edge, so no idle cycle between lines
              seg_d = seg_nxt[1:0];
              st_start = 1'b1;
              st_seg = seg_ends(shape_q, seg_nxt[1:0], x0_q, y0_q, x1_q, y1_q);
            end
          end
        end
      end
      default: begin
        if (xfer) begin
          if (clr_x_q == 13'(CANVAS_W - 1)) begin
            clr_x_d = '0;
            if (clr_y_q == 13'(CANVAS_H - 1)) state_d = ST_IDLE;
            else clr_y_d = clr_y_q + 13'd1;
          end else begin
            clr_x_d = clr_x_q + 13'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE; shape_q <= '0; seg_q <= '0;
      x0_q <= '0; y0_q <= '0; x1_q <= '0; y1_q <= '0; color_q <= '0;
      clr_x_q <= '0; clr_y_q <= '0;
      clr_prev_q <= 1'b0; pend_clr_q <= 1'b0; drop_q <= 1'b0;
    end else begin
      state_q <= state_d; shape_q <= shape_d; seg_q <= seg_d;
      x0_q <= x0_d; y0_q <= y0_d; x1_q <= x1_d; y1_q <= y1_d; color_q <= color_d;
      clr_x_q <= clr_x_d; clr_y_q <= clr_y_d;
      clr_prev_q <= i_clear; pend_clr_q <= pend_clr_d; drop_q <= drop_d;
    end
  end

  line_stepper u_stepper (
    .clk     (clk),
    .rst     (rst),
    .start   (st_start),
    .x0      (st_seg.xa),
    .y0      (st_seg.ya),
    .x1      (st_seg.xb),
    .y1      (st_seg.yb),
    .advance (xfer && (state_q == ST_DRAW)),
    .px      (st_x),
    .py      (st_y),
    .valid   (st_valid),
    .done    (st_done)
  );

  assign o_wr_req  = ((state_q == ST_DRAW) && st_valid) || (state_q == ST_CLEAR);
  assign o_wr_x    = (state_q == ST_CLEAR) ? clr_x_q : (state_q == ST_DRAW) ? st_x : 13'd0;
  assign o_wr_y    = (state_q == ST_CLEAR) ? clr_y_q : (state_q == ST_DRAW) ? st_y : 13'd0;
  assign o_wr_data = (state_q == ST_DRAW) ? color_q : COLOR_TRANSPARENT;
  assign o_busy    = busy;
  assign o_drop    = drop_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_shape_painter.sv
// Directed bench for shape_painter; the canvas is shrunk to 120x110 so a full
// wipe stays short while the 100..102 rectangle and the x=750 miss still apply.
module tb_shape_painter;
  import paint_pkg::*;

  localparam int W = 120;
  localparam int H = 110;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_pt_valid = 1'b0;
  logic [12:0] i_pt_x = '0, i_pt_y = '0;
  logic [2:0]  i_draw_shape = '0;
  logic [15:0] i_color = '0;
  logic        i_clear = 1'b0;
  logic        i_wr_ack = 1'b1;
  logic        o_wr_req, o_busy, o_drop;
  logic [12:0] o_wr_x, o_wr_y;
  logic [15:0] o_wr_data;
  logic [1:0]  o_state;

  int checks = 0;
  int errors = 0;

  logic [41:0] exp_q[$];
  logic [41:0] got_q[$];
  int drop_seen, stall_bad, busy_cycles;
  bit timed_out;

  always #5 clk = ~clk;

  shape_painter #(.CANVAS_W(W), .CANVAS_H(H)) dut (
    .clk(clk), .rst(rst), .i_pt_valid(i_pt_valid), .i_pt_x(i_pt_x), .i_pt_y(i_pt_y),
    .i_draw_shape(i_draw_shape), .i_color(i_color), .i_clear(i_clear),
    .o_wr_req(o_wr_req), .o_wr_x(o_wr_x), .o_wr_y(o_wr_y), .o_wr_data(o_wr_data),
    .i_wr_ack(i_wr_ack), .o_busy(o_busy), .o_drop(o_drop), .o_state(o_state)
  );

  function automatic logic [41:0] pix(input int x, input int y, input logic [15:0] d);
    return {13'(x), 13'(y), d};
  endfunction

  task automatic send_point(input int x, input int y);
    @(negedge clk);
    i_pt_x = 13'(x); i_pt_y = 13'(y); i_pt_valid = 1'b1;
    @(negedge clk);
    i_pt_valid = 1'b0;
  endtask

  // Records every accepted pixel while o_busy is high; optional point injection.
  task automatic collect(input int max_cycles, input bit rand_ack, input int inject_at,
                         input int inj_x, input int inj_y);
    logic [41:0] held;
    bit stalled;
    got_q.delete();
    drop_seen = 0; stall_bad = 0; busy_cycles = 0; timed_out = 0; stalled = 0; held = '0;
    while (o_busy) begin
      if (busy_cycles >= max_cycles) begin timed_out = 1; break; end
      if (stalled && (!o_wr_req || {o_wr_x, o_wr_y, o_wr_data} != held)) stall_bad++;
      i_wr_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = o_wr_req && !i_wr_ack;
      held = {o_wr_x, o_wr_y, o_wr_data};
      if (o_wr_req && i_wr_ack) got_q.push_back(held);
      if (busy_cycles == inject_at) begin
        i_pt_x = 13'(inj_x); i_pt_y = 13'(inj_y); i_pt_valid = 1'b1;
      end
      busy_cycles++;
      @(negedge clk);
      i_pt_valid = 1'b0;
      if (o_drop) drop_seen++;
    end
    i_wr_ack = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (o_wr_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", o_wr_req); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
    checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b expected 0", o_drop); end
    checks++; if ({o_wr_x, o_wr_y, o_wr_data} !== 42'd0) begin
      errors++; $display("FAIL rst_addr_data: got x=%0d y=%0d d=%h expected all zero", o_wr_x, o_wr_y, o_wr_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", o_state); end
  endtask

  task automatic test_direct();
    i_draw_shape = SHAPE_DIRECT; i_color = 16'hFC00;
    send_point(5, 7);
    checks++; if (o_busy !== 1'b1 || o_wr_req !== 1'b1) begin
      errors++; $display("FAIL direct_req: got busy=%b req=%b expected 1 1", o_busy, o_wr_req);
    end
    checks++; if ({o_wr_x, o_wr_y, o_wr_data} !== pix(5, 7, 16'hFC00)) begin
      errors++; $display("FAIL direct_pix: got x=%0d y=%0d d=%h expected 5 7 fc00", o_wr_x, o_wr_y, o_wr_data);
    end
    @(negedge clk);
    checks++; if (o_busy !== 1'b0 || o_wr_req !== 1'b0 || o_state !== 2'd0) begin
      errors++; $display("FAIL direct_end: got busy=%b req=%b state=%0d expected 0 0 0", o_busy, o_wr_req, o_state);
    end
  endtask

  task automatic test_line();
    i_draw_shape = SHAPE_LINE; i_color = 16'h83E0;
    send_point(10, 10);
    checks++; if (o_state !== 2'd1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL line_armed: got state=%0d busy=%b expected 1 0", o_state, o_busy);
    end
    send_point(13, 12);
    collect(50, 0, -1, 0, 0);
    exp_q = '{pix(10, 10, 16'h83E0), pix(11, 11, 16'h83E0), pix(12, 11, 16'h83E0), pix(13, 12, 16'h83E0)};
    checks++; if (timed_out || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL line_count: got %0d writes (timeout=%0d) expected %0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL line_pix[%0d]: got x=%0d y=%0d d=%h expected x=%0d y=%0d d=%h", i,
          got_q[i][41:29], got_q[i][28:16], got_q[i][15:0], exp_q[i][41:29], exp_q[i][28:16], exp_q[i][15:0]);
      end
    end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL line_idle: got state %0d expected 0", o_state); end
  endtask

  task automatic test_rect_stall();
    logic [15:0] c;
    c = 16'h801F;
    i_draw_shape = SHAPE_RECT; i_color = c;
    send_point(100, 100);
    send_point(102, 101);
    collect(400, 1, -1, 0, 0);
    exp_q = '{pix(100, 100, c), pix(101, 100, c), pix(102, 100, c),
              pix(102, 100, c), pix(102, 101, c),
              pix(102, 101, c), pix(101, 101, c), pix(100, 101, c),
              pix(100, 101, c), pix(100, 100, c)};
    checks++; if (timed_out || got_q.size() != 10) begin
      errors++; $display("FAIL rect_count: got %0d writes (timeout=%0d) expected 10", got_q.size(), timed_out);
    end
    checks++; if (stall_bad != 0) begin
      errors++; $display("FAIL rect_stall_hold: got %0d unstable stall cycles expected 0", stall_bad);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rect_pix[%0d]: got x=%0d y=%0d expected x=%0d y=%0d", i,
          got_q[i][41:29], got_q[i][28:16], exp_q[i][41:29], exp_q[i][28:16]);
      end
    end
  endtask

  task automatic test_triangle();
    logic [15:0] c;
    c = 16'hFFFF;
    i_draw_shape = SHAPE_TRI; i_color = c;
    send_point(0, 0);
    send_point(4, 2);
    collect(100, 0, -1, 0, 0);
    exp_q = '{pix(0, 2, c), pix(1, 2, c), pix(2, 2, c), pix(3, 2, c), pix(4, 2, c),
              pix(4, 2, c), pix(3, 1, c), pix(2, 0, c),
              pix(2, 0, c), pix(1, 1, c), pix(0, 2, c)};
    checks++; if (timed_out || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL tri_count: got %0d writes (timeout=%0d) expected %0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL tri_pix[%0d]: got x=%0d y=%0d expected x=%0d y=%0d", i,
          got_q[i][41:29], got_q[i][28:16], exp_q[i][41:29], exp_q[i][28:16]);
      end
    end
  endtask

  task automatic test_out_of_canvas();
    int reqs;
    reqs = 0;
    i_draw_shape = SHAPE_DIRECT;
    send_point(750, 200);
    send_point(50, H);
    repeat (4) begin
      if (o_wr_req || o_busy) reqs++;
      @(negedge clk);
    end
    checks++; if (reqs != 0 || o_state !== 2'd0) begin
      errors++; $display("FAIL menu_hit: got %0d busy cycles state=%0d expected 0 0", reqs, o_state);
    end
    i_draw_shape = SHAPE_LINE;
    send_point(10, 10);
    send_point(10, 200);
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL armed_menu_hit: got state %0d expected 1", o_state); end
    @(negedge clk);
    i_draw_shape = SHAPE_RECT;
    @(negedge clk);
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL armed_abort: got state %0d expected 0", o_state); end
    i_draw_shape = 3'd0;
  endtask

  task automatic test_drop();
    i_draw_shape = SHAPE_LINE; i_color = 16'h8421;
    send_point(0, 0);
    send_point(20, 0);
    collect(100, 0, 5, 1, 1);
    checks++; if (timed_out || got_q.size() != 21) begin
      errors++; $display("FAIL drop_count: got %0d writes (timeout=%0d) expected 21", got_q.size(), timed_out);
    end
    checks++; if (drop_seen != 1) begin errors++; $display("FAIL drop_pulse: got %0d pulses expected 1", drop_seen); end
    checks++; if (got_q.size() > 0 && got_q[got_q.size()-1] !== pix(20, 0, 16'h8421)) begin
      errors++; $display("FAIL drop_last: got x=%0d y=%0d expected 20 0",
        got_q[got_q.size()-1][41:29], got_q[got_q.size()-1][28:16]);
    end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL drop_idle: got state %0d expected 0", o_state); end
  endtask

  task automatic test_clear();
    int bad;
    bad = 0;
    @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    checks++; if (o_state !== 2'd3 || o_busy !== 1'b1) begin
      errors++; $display("FAIL clear_enter: got state=%0d busy=%b expected 3 1", o_state, o_busy);
    end
    collect(W * H + 50, 0, -1, 0, 0);
    checks++; if (timed_out || got_q.size() != W * H) begin
      errors++; $display("FAIL clear_count: got %0d writes (timeout=%0d) expected %0d", got_q.size(), timed_out, W * H);
    end
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== pix(i % W, i / W, 16'h0000)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_order: got %0d misplaced writes expected 0", bad); end
    checks++; if (got_q.size() > 0 && got_q[got_q.size()-1] !== pix(W - 1, H - 1, 16'h0000)) begin
      errors++; $display("FAIL clear_last: got x=%0d y=%0d expected %0d %0d",
        got_q[got_q.size()-1][41:29], got_q[got_q.size()-1][28:16], W - 1, H - 1);
    end
    checks++; if (busy_cycles != W * H || o_busy !== 1'b0) begin
      errors++; $display("FAIL clear_busy_fall: got %0d busy cycles busy=%b expected %0d 0", busy_cycles, o_busy, W * H);
    end
    i_clear = 1'b0;
  endtask

  task automatic test_clear_during_draw();
    i_draw_shape = SHAPE_LINE; i_color = 16'hABCD;
    send_point(0, 50);
    send_point(30, 50);
    repeat (3) @(negedge clk);
    i_clear = 1'b1;
    collect(W * H + 100, 0, -1, 0, 0);
    checks++; if (timed_out || got_q.size() != W * H + 1) begin
      errors++; $display("FAIL clr_draw_count: got %0d writes (timeout=%0d) expected %0d", got_q.size(), timed_out, W * H + 1);
    end
    checks++; if (got_q.size() > 1 && (got_q[0] !== pix(3, 50, 16'hABCD) || got_q[1] !== pix(0, 0, 16'h0000))) begin
      errors++; $display("FAIL clr_draw_switch: got x=%0d y=%0d then x=%0d y=%0d d=%h expected 3 50 then 0 0 0000",
        got_q[0][41:29], got_q[0][28:16], got_q[1][41:29], got_q[1][28:16], got_q[1][15:0]);
    end
    i_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sweep();
    int reqs;
    reqs = 0;
    @(negedge clk);
    i_clear = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (o_wr_req !== 1'b1) begin errors++; $display("FAIL sweep_running: got req %b expected 1", o_wr_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if (o_wr_req !== 1'b0 || o_busy !== 1'b0 || o_state !== 2'd0) begin
      errors++; $display("FAIL async_reset: got req=%b busy=%b state=%0d expected 0 0 0", o_wr_req, o_busy, o_state);
    end
    i_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (o_wr_req || o_busy) reqs++;
    end
    checks++; if (reqs != 0 || o_state !== 2'd0) begin
      errors++; $display("FAIL no_resume: got %0d active cycles state=%0d expected 0 0", reqs, o_state);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_line();
    test_rect_stall();
    test_triangle();
    test_out_of_canvas();
    test_drop();
    test_clear();
    test_clear_during_draw();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
